// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler in front of a 4:1 transmission-gate mux.
// One requester at a time owns the mux. A holder is preempted after MAX_HOLD
// cycles when someone else is waiting. Every handover passes through
// GAP_CYCLES dead cycles with the mux disabled, so two gate paths are never
// on while the select lines move.
module mux4_rr_sched #(
   parameter int unsigned MAX_HOLD   = 8,
   parameter int unsigned GAP_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic       s0,
   output logic       s1,
   output logic       mux_en,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      GAP
   } state_t;

   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
   localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);

   state_t     state;
   logic [1:0] cur_idx;
   logic [1:0] last_idx;
   logic [7:0] hold_cnt;
   logic [3:0] gap_cnt;

   logic [1:0] pick;
   logic [1:0] cand;
   logic       found;
   logic       release_now;
   logic       preempt_now;

   function automatic logic [3:0] onehot(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

   // Round-robin search starting just after the last winner and wrapping
   // around to the last winner itself, so it only wins when nobody else asks.
   always_comb begin
      pick  = last_idx;
      cand  = last_idx;
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         cand = last_idx + 2'(k);
         if (!found && req[cand]) begin
            pick  = cand;
            found = 1'b1;
         end
      end
   end

   // Exit conditions for the current holder: it let go, or it used up its
   // hold budget while another requester is waiting.
   always_comb begin
      release_now = ~req[cur_idx];
      preempt_now = (hold_cnt == HOLD_LAST) && ((req & ~onehot(cur_idx)) != 4'b0000);
   end

   // Scheduler state machine; every output is a register loaded here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cur_idx  <= 2'd0;
         last_idx <= 2'd3;
         hold_cnt <= 8'd0;
         gap_cnt  <= 4'd0;
         gnt      <= 4'b0000;
         s0       <= 1'b0;
         s1       <= 1'b0;
         mux_en   <= 1'b0;
         busy     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req != 4'b0000) begin
                  state    <= GRANT;
                  cur_idx  <= pick;
                  last_idx <= pick;
                  hold_cnt <= 8'd0;
                  gnt      <= onehot(pick);
                  s0       <= pick[0];
                  s1       <= pick[1];
                  mux_en   <= 1'b1;
                  busy     <= 1'b1;
               end
            end

            GRANT: begin
               if (release_now || preempt_now) begin
                  state   <= GAP;
                  gap_cnt <= 4'd0;
                  gnt     <= 4'b0000;
                  mux_en  <= 1'b0;
                  busy    <= 1'b1;
               end else if (hold_cnt != HOLD_LAST) begin
                  hold_cnt <= hold_cnt + 8'd1;
               end
            end

            GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  if (req != 4'b0000) begin
                     state    <= GRANT;
                     cur_idx  <= pick;
                     last_idx <= pick;
                     hold_cnt <= 8'd0;
                     gnt      <= onehot(pick);
                     s0       <= pick[0];
                     s1       <= pick[1];
                     mux_en   <= 1'b1;
                     busy     <= 1'b1;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  gap_cnt <= gap_cnt + 4'd1;
               end
            end

            default: begin
               state  <= IDLE;
               gnt    <= 4'b0000;
               mux_en <= 1'b0;
               busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule
